// File: rtl/vector_expander_pkg.sv
// vector_expander_pkg: shared FSM state type and reference source-index function.
package vector_expander_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int src_index(int out_idx, int in_cnt, int out_cnt);
    int r;
    r = (out_idx * in_cnt) / out_cnt;
    return (r > in_cnt - 1) ? in_cnt - 1 : r;
  endfunction
endpackage

// File: rtl/vector_expander_if.sv
// vector_expander_if: request/result bundle between a layer stage and the expander.
interface vector_expander_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int INPUT_COUNT  = 8,
  parameter int OUTPUT_COUNT = 16
);
  logic                               start;
  logic [DATA_WIDTH*INPUT_COUNT-1:0]  vector_in;
  logic [DATA_WIDTH*OUTPUT_COUNT-1:0] vector_out;
  logic                               busy;
  logic                               done;
  modport master (output start, vector_in, input vector_out, busy, done);
  modport slave  (input start, vector_in, output vector_out, busy, done);
endinterface

// File: rtl/expander_index_gen.sv
// expander_index_gen: accumulator stepper giving src_idx = floor(out_idx*IN/OUT) without a divider.
module expander_index_gen
  import vector_expander_pkg::*;
#(
  parameter int INPUT_COUNT  = 8,
  parameter int OUTPUT_COUNT = 16,
  localparam int OW = OUTPUT_COUNT > 1 ? $clog2(OUTPUT_COUNT) : 1,
  localparam int SW = INPUT_COUNT > 1 ? $clog2(INPUT_COUNT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [OW-1:0] out_idx,
  output logic [SW-1:0] src_idx,
  output logic          last
);
  localparam int AW = $clog2(INPUT_COUNT + OUTPUT_COUNT + 1);
  logic [AW-1:0] acc, acc_n;
  logic          wrap;
  assign acc_n = acc + AW'(INPUT_COUNT);
  assign wrap  = acc_n >= AW'(OUTPUT_COUNT);
  assign last  = out_idx == OW'(OUTPUT_COUNT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      acc     <= '0;
      out_idx <= '0;
      src_idx <= '0;
    end else if (step) begin
      out_idx <= out_idx + OW'(1);
      acc     <= wrap ? acc_n - AW'(OUTPUT_COUNT) : acc_n;
      src_idx <= (wrap && src_idx != SW'(INPUT_COUNT - 1)) ? src_idx + SW'(1) : src_idx;
    end
  end
  always @(posedge clk)
    if (rst && step) assert (int'(src_idx) == src_index(int'(out_idx), INPUT_COUNT, OUTPUT_COUNT));
endmodule

// File: rtl/vector_expander.sv
// vector_expander: nearest-neighbour upsampler, one output element written per clock.
module vector_expander
  import vector_expander_pkg::*;
#(
  parameter int INPUT_COUNT  = 8,
  parameter int OUTPUT_COUNT = 16,
  parameter int DATA_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst,
  vector_expander_if.slave bus
);
  localparam int OW = OUTPUT_COUNT > 1 ? $clog2(OUTPUT_COUNT) : 1;
  localparam int SW = INPUT_COUNT > 1 ? $clog2(INPUT_COUNT) : 1;
  if (INPUT_COUNT < 1 || OUTPUT_COUNT < INPUT_COUNT) begin : g_bad_params
    $error("vector_expander: need 1 <= INPUT_COUNT <= OUTPUT_COUNT");
  end
  state_t                                      state, nxt;
  logic [INPUT_COUNT-1:0][DATA_WIDTH-1:0]      in_q;
  logic [OUTPUT_COUNT-1:0][DATA_WIDTH-1:0]     out_q;
  logic [OW-1:0]                               out_idx;
  logic [SW-1:0]                               src_idx;
  logic                                        last, load, step;
  assign load = state == IDLE && bus.start;
  assign step = state == RUN;
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      in_q  <= '0;
      out_q <= '0;
    end else begin
      state <= nxt;
      if (load) in_q <= bus.vector_in;
      if (step) out_q[out_idx] <= in_q[src_idx];
    end
  end
  expander_index_gen #(.INPUT_COUNT(INPUT_COUNT), .OUTPUT_COUNT(OUTPUT_COUNT)) u_idx (
    .clk(clk), .rst(rst), .clear(load), .step(step),
    .out_idx(out_idx), .src_idx(src_idx), .last(last)
  );
  assign bus.vector_out = out_q;
  assign bus.busy       = state == RUN;
  assign bus.done       = state == DONE;
endmodule

// File: tb/tb_vector_expander.sv
// tb_vector_expander: directed checks of the 8->16 and 3->8 expander configurations.
module tb_vector_expander;
  logic clk = 0;
  logic rst = 0;
  int   pass = 0;
  int   total = 0;
  always #5 clk = ~clk;

  vector_expander_if #(.DATA_WIDTH(16), .INPUT_COUNT(8), .OUTPUT_COUNT(16)) b0 ();
  vector_expander_if #(.DATA_WIDTH(16), .INPUT_COUNT(3), .OUTPUT_COUNT(8))  b1 ();
  vector_expander #(.INPUT_COUNT(8), .OUTPUT_COUNT(16), .DATA_WIDTH(16)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
  vector_expander #(.INPUT_COUNT(3), .OUTPUT_COUNT(8),  .DATA_WIDTH(16)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));

  function automatic logic [127:0] mk(int off);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'((k + off) * 16);
    return v;
  endfunction

  task automatic run0(input logic [127:0] v, output int cyc);
    @(negedge clk);
    b0.start = 1;
    b0.vector_in = v;
    @(negedge clk);
    b0.start = 0;
    cyc = 1;
    while (!b0.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++; if (b0.vector_out !== '0) $display("FAIL reset_vout got %h want 0", b0.vector_out); else pass++;
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) $display("FAIL reset_flags busy=%b done=%b want 0/0", b0.busy, b0.done); else pass++;
    total++; if (b1.vector_out !== '0 || b1.busy !== 1'b0 || b1.done !== 1'b0) $display("FAIL reset_d1 got %h/%b/%b want 0", b1.vector_out, b1.busy, b1.done); else pass++;
  endtask

  task automatic test_default(input int off, input string tag);
    int cyc;
    run0(mk(off), cyc);
    total++; if (cyc !== 17) $display("FAIL %s_latency got %0d want 17", tag, cyc); else pass++;
    total++; if (b0.busy !== 1'b0) $display("FAIL %s_busy_at_done got %b want 0", tag, b0.busy); else pass++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (b0.vector_out[i*16 +: 16] !== 16'((i/2 + off) * 16))
        $display("FAIL %s_out[%0d] got %0d want %0d", tag, i, b0.vector_out[i*16 +: 16], (i/2 + off) * 16);
      else pass++;
    end
    @(negedge clk);
    total++; if (b0.done !== 1'b0) $display("FAIL %s_done_pulse got %b want 0", tag, b0.done); else pass++;
  endtask

  task automatic test_ratio;
    int cyc;
    logic [15:0] exp1 [8];
    exp1 = '{16'd5, 16'd5, 16'd5, -16'sd7, -16'sd7, -16'sd7, 16'd9, 16'd9};
    @(negedge clk);
    b1.start = 1;
    b1.vector_in = {16'd9, -16'sd7, 16'd5};
    @(negedge clk);
    b1.start = 0;
    b1.vector_in = '1;
    cyc = 1;
    while (!b1.done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc !== 9) $display("FAIL ratio_latency got %0d want 9", cyc); else pass++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (b1.vector_out[i*16 +: 16] !== exp1[i])
        $display("FAIL ratio_out[%0d] got %h want %h", i, b1.vector_out[i*16 +: 16], exp1[i]);
      else pass++;
    end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    @(negedge clk);
    b0.start = 1;
    b0.vector_in = mk(1);
    @(negedge clk);
    b0.start = 0;
    repeat (3) @(negedge clk);
    total++; if (b0.busy !== 1'b1) $display("FAIL swb_busy got %b want 1", b0.busy); else pass++;
    b0.start = 1;
    b0.vector_in = mk(9);
    @(negedge clk);
    b0.start = 0;
    for (int c = 0; c < 30; c++) begin
      if (b0.done) dones++;
      @(negedge clk);
    end
    total++; if (dones !== 1) $display("FAIL swb_done_count got %0d want 1", dones); else pass++;
    for (int i = 0; i < 16; i += 5) begin
      total++;
      if (b0.vector_out[i*16 +: 16] !== 16'((i/2 + 1) * 16))
        $display("FAIL swb_out[%0d] got %0d want %0d", i, b0.vector_out[i*16 +: 16], (i/2 + 1) * 16);
      else pass++;
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    b0.start = 1;
    b0.vector_in = mk(5);
    @(negedge clk);
    b0.start = 0;
    repeat (4) @(negedge clk);
    rst = 0;
    #1;
    total++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) $display("FAIL midrst_flags busy=%b done=%b want 0/0", b0.busy, b0.done); else pass++;
    total++; if (b0.vector_out !== '0) $display("FAIL midrst_vout got %h want 0", b0.vector_out); else pass++;
    @(negedge clk);
    rst = 1;
    test_default(2, "after_rst");
  endtask

  initial begin
    b0.start = 0; b0.vector_in = '0;
    b1.start = 0; b1.vector_in = '0;
    test_reset;
    test_default(0, "def0");
    test_default(3, "def3");
    test_ratio;
    test_start_while_busy;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
